// File: rtl/fp_add_seq.sv
// fp_add_seq: multi-cycle IEEE-style adder/subtractor with truncation, flushed zero
// exponents, and either free-running or single-step sequencing through its states.
module fp_add_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 manual,
  input  logic                 step,
  input  logic                 op,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 done,
  output logic                 busy,
  output logic                 overflow,
  output logic                 underflow,
  output logic [4:0]           state_led
);
  localparam int N = 1 + EXP_W + MAN_W;
  localparam int M = MAN_W + 2;
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [EXP_W-1:0] SH_LIM   = EXP_W'(MAN_W + 1);

  typedef enum logic [4:0] {
    S_IDLE  = 5'b00001,
    S_ALIGN = 5'b00010,
    S_ADD   = 5'b00100,
    S_NORM  = 5'b01000,
    S_DONE  = 5'b10000
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [N-1:0]     r_a, r_b, r_result;
  logic             r_op, r_sx, r_sub, r_done, r_ovf, r_unf;
  logic [EXP_W-1:0] r_exp;
  logic [M-1:0]     r_mx, r_my, r_mag;

  logic             w_adv;
  logic [EXP_W-1:0] w_ea, w_eb, w_ex, w_ey, w_diff;
  logic [M-1:0]     w_ma, w_mb, w_mx, w_my, w_my_sh;
  logic             w_sa, w_sb, w_sx, w_sy, w_a_ge;
  logic [EXP_W:0]   w_exp_inc;
  logic             w_mag_zero, w_carry, w_hidden, w_exp_low, w_norm_end;

  assign w_adv = !manual || step;

  // Operand decode, magnitude ordering and alignment of the smaller operand.
  always_comb begin
    w_ea    = r_a[N-2:MAN_W];
    w_eb    = r_b[N-2:MAN_W];
    w_ma    = (w_ea == '0) ? '0 : {2'b01, r_a[MAN_W-1:0]};
    w_mb    = (w_eb == '0) ? '0 : {2'b01, r_b[MAN_W-1:0]};
    w_sa    = r_a[N-1];
    w_sb    = r_b[N-1] ^ r_op;
    w_a_ge  = (w_ea > w_eb) || ((w_ea == w_eb) && (w_ma >= w_mb));
    w_ex    = w_a_ge ? w_ea : w_eb;
    w_ey    = w_a_ge ? w_eb : w_ea;
    w_mx    = w_a_ge ? w_ma : w_mb;
    w_my    = w_a_ge ? w_mb : w_ma;
    w_sx    = w_a_ge ? w_sa : w_sb;
    w_sy    = w_a_ge ? w_sb : w_sa;
    w_diff  = w_ex - w_ey;
    w_my_sh = (w_diff >= SH_LIM) ? '0 : (w_my >> w_diff);
  end

  always_comb begin
    w_exp_inc  = {1'b0, r_exp} + (EXP_W+1)'(1);
    w_mag_zero = (r_mag == '0);
    w_carry    = r_mag[M-1];
    w_hidden   = r_mag[M-2];
    w_exp_low  = (r_exp <= EXP_W'(1));
    w_norm_end = w_mag_zero || w_carry || w_hidden || w_exp_low;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)               w_state_nxt = S_ALIGN;
      S_ALIGN: if (w_adv)               w_state_nxt = S_ADD;
      S_ADD:   if (w_adv)               w_state_nxt = S_NORM;
      S_NORM:  if (w_adv && w_norm_end) w_state_nxt = S_DONE;
      S_DONE:  if (w_adv)               w_state_nxt = S_IDLE;
      default:                          w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // The final NORM step writes result and raises done together, so both are
  // visible during the DONE cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_result <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_a   <= a;
          r_b   <= b;
          r_op  <= op;
          r_ovf <= 1'b0;
          r_unf <= 1'b0;
        end
        S_ALIGN: if (w_adv) begin
          r_sx  <= w_sx;
          r_sub <= w_sx ^ w_sy;
          r_exp <= w_ex;
          r_mx  <= w_mx;
          r_my  <= w_my_sh;
        end
        S_ADD: if (w_adv) r_mag <= r_sub ? (r_mx - r_my) : (r_mx + r_my);
        S_NORM: if (w_adv) begin
          if (w_norm_end) r_done <= 1'b1;
          if (w_mag_zero) begin
            r_result <= '0;
          end else if (w_carry) begin
            if (w_exp_inc >= {1'b0, EXP_ONES}) begin
              r_result <= {r_sx, EXP_ONES, {MAN_W{1'b0}}};
              r_ovf    <= 1'b1;
            end else begin
              r_result <= {r_sx, w_exp_inc[EXP_W-1:0], r_mag[MAN_W:1]};
            end
          end else if (w_hidden) begin
            if (r_exp == EXP_ONES) begin
              r_result <= {r_sx, EXP_ONES, {MAN_W{1'b0}}};
              r_ovf    <= 1'b1;
            end else begin
              r_result <= {r_sx, r_exp, r_mag[MAN_W-1:0]};
            end
          end else if (w_exp_low) begin
            r_result <= '0;
            r_unf    <= 1'b1;
          end else begin
            r_mag <= r_mag << 1;
            r_exp <= r_exp - EXP_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign done      = r_done;
  assign busy      = (r_state != S_IDLE);
  assign overflow  = r_ovf;
  assign underflow = r_unf;
  assign state_led = r_state;
endmodule

// File: tb/tb_fp_add_seq.sv
// Bench for fp_add_seq: directed vectors, step mode, reset, and random operations
// compared against an arithmetic reference model.
module tb_fp_add_seq;
  logic        clk = 1'b0, reset = 1'b0, start = 1'b0, manual = 1'b0, step = 1'b0, op = 1'b0;
  logic [31:0] a = '0, b = '0, result;
  logic        done, busy, overflow, underflow;
  logic [4:0]  state_led;
  int          n_total = 0, n_bad = 0;

  always #5 clk = ~clk;

  fp_add_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .reset(reset), .start(start), .manual(manual), .step(step), .op(op),
    .a(a), .b(b), .result(result), .done(done), .busy(busy),
    .overflow(overflow), .underflow(underflow), .state_led(state_led)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer significands, truncating alignment, leading-one search.
  function automatic void ref_add(input logic [31:0] xa, input logic [31:0] xb, input logic xop,
                                  output logic [31:0] res, output logic ovf, output logic unf,
                                  output int lat);
    longint ea, eb, siga, sigb, ex, ey, sigx, sigy, d, m, e;
    logic   sa, sb, sx, sy;
    int     p, sh;
    ea = longint'(xa[30:23]);
    eb = longint'(xb[30:23]);
    siga = (ea == 0) ? 0 : (longint'(1) << 23) + longint'(xa[22:0]);
    sigb = (eb == 0) ? 0 : (longint'(1) << 23) + longint'(xb[22:0]);
    sa = xa[31];
    sb = xb[31] ^ xop;
    if (ea > eb || (ea == eb && siga >= sigb)) begin
      ex = ea; sigx = siga; sx = sa; ey = eb; sigy = sigb; sy = sb;
    end else begin
      ex = eb; sigx = sigb; sx = sb; ey = ea; sigy = siga; sy = sa;
    end
    d = ex - ey;
    sigy = (d >= 24) ? 0 : (sigy >> d);
    m = (sx == sy) ? sigx + sigy : sigx - sigy;
    res = '0; ovf = 1'b0; unf = 1'b0; lat = 3;
    if (m == 0) return;
    if (m >= (longint'(1) << 24)) begin
      e = ex + 1;
      if (e >= 255) begin res = {sx, 8'hFF, 23'h0}; ovf = 1'b1; end
      else res = {sx, 8'(e), 23'(m >> 1)};
      return;
    end
    p = 0;
    for (int i = 0; i < 25; i++) if (m >= (longint'(1) << i)) p = i;
    sh = 23 - p;
    if (ex - sh < 1) begin
      unf = 1'b1;
      lat = 3 + int'(ex) - 1;
    end else begin
      e = ex - sh;
      lat = 3 + sh;
      if (e >= 255) begin res = {sx, 8'hFF, 23'h0}; ovf = 1'b1; end
      else res = {sx, 8'(e), 23'(m << sh)};
    end
  endfunction

  task automatic run_op(input logic [31:0] xa, input logic [31:0] xb, input logic xop, input string tag);
    logic [31:0] er;
    logic        eo, eu;
    int          el, k;
    ref_add(xa, xb, xop, er, eo, eu, el);
    a = xa; b = xb; op = xop; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom);
    check({tag, " busy/flags"}, {busy, overflow, underflow}, 3'b100);
    k = 0;
    while (!done && k < 60) begin
      start = (k % 3 == 1);
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    check({tag, " latency"}, k, el);
    check({tag, " result"}, result, er);
    check({tag, " flags"}, {overflow, underflow}, {eo, eu});
    @(posedge clk); #1;
    check({tag, " idle"}, {done, busy, state_led}, {1'b0, 1'b0, 5'b00001});
    check({tag, " hold"}, {result, overflow, underflow}, {er, eo, eu});
  endtask

  function automatic logic [31:0] rnd_fp(input int e);
    return {1'($urandom), 8'(e), 23'($urandom)};
  endfunction

  initial begin
    int          ea, eb, dones;
    logic [31:0] ra, rb;
    logic [4:0]  walk [3];
    walk[0] = 5'b00100; walk[1] = 5'b01000; walk[2] = 5'b10000;

    reset = 1'b0; start = 1'b1; step = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", {result, done, busy, overflow, underflow, state_led},
          {32'h0, 4'b0000, 5'b00001});
    reset = 1'b1; start = 1'b0; step = 1'b0;
    @(posedge clk); #1;

    run_op(32'h3F800000, 32'h3F800000, 1'b0, "add 1+1");
    check("add 1+1 const", result, 32'h40000000);
    run_op(32'h40400000, 32'h3F800000, 1'b1, "sub 3-1");
    check("sub 3-1 const", result, 32'h40000000);
    run_op(32'h3FC00000, 32'h3FC00000, 1'b1, "cancel");
    check("cancel const", {result, underflow}, {32'h0, 1'b0});
    run_op(32'h3F800001, 32'h3F800000, 1'b1, "lsb diff");
    check("lsb diff const", result, 32'h34000000);
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, "overflow");
    check("overflow const", {result, overflow}, {32'h7F800000, 1'b1});
    repeat (5) @(posedge clk);
    #1;
    check("overflow sticky", overflow, 1'b1);
    run_op(32'h00800001, 32'h00800000, 1'b1, "underflow e1");
    run_op(32'h01000001, 32'h01000000, 1'b1, "underflow e2");
    check("underflow const", {result, underflow}, {32'h0, 1'b1});
    run_op(32'h00000000, 32'h80000000, 1'b0, "zeros");

    manual = 1'b1;
    a = 32'h3F800000; b = 32'h3F800000; op = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("step align", state_led, 5'b00010);
    repeat (6) @(posedge clk);
    #1;
    check("step hold", state_led, 5'b00010);
    for (int i = 0; i < 3; i++) begin
      step = 1'b1;
      @(posedge clk); #1;
      step = 1'b0;
      check("step walk", state_led, walk[i]);
    end
    check("step done", {done, result}, {1'b1, 32'h40000000});
    @(posedge clk); #1;
    check("step done pulse", {done, state_led}, {1'b0, 5'b10000});
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    check("step idle", state_led, 5'b00001);
    manual = 1'b0;

    a = 32'h3F800001; b = 32'h3F800000; op = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 10 && state_led != 5'b01000; i++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reach norm", state_led, 5'b01000);
    reset = 1'b0; start = 1'b1; step = 1'b1;
    @(posedge clk); #1;
    check("midop reset", {result, done, busy, state_led}, {32'h0, 2'b00, 5'b00001});
    reset = 1'b1; start = 1'b0; step = 1'b0;
    dones = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("no done after reset", dones, 0);

    for (int n = 0; n < 300; n++) begin
      ea = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 254));
      case ($urandom_range(0, 3))
        0: eb = int'($urandom_range(0, 254));
        1: begin
          eb = ea + int'($urandom_range(0, 4)) - 2;
          if (eb < 0) eb = 0;
          if (eb > 254) eb = 254;
        end
        3: begin
          ea = int'($urandom_range(1, 4));
          eb = int'($urandom_range(1, 4));
        end
        default: eb = ea;
      endcase
      ra = rnd_fp(ea);
      rb = rnd_fp(eb);
      if (ea == eb && $urandom_range(0, 1) == 1) rb = ra ^ 32'($urandom_range(0, 1023));
      run_op(ra, rb, 1'($urandom), "random");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
